// File: rtl/mandel_pkg.sv
// Shared constants and FSM encoding for the Mandelbrot work scheduler.
package mandel_pkg;
  localparam int COORD_W_DEF = 10;
  localparam int RGB_W_DEF   = 24;
  localparam int X_SIZE_DEF  = 640;
  localparam int Y_SIZE_DEF  = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;
endpackage

// File: rtl/mandel_work_scheduler_raster_counter.sv
// Raster-order pixel walker: x, y and the engine that owns the current pixel.
module raster_counter
  import mandel_pkg::*;
#(
  parameter int X_SIZE  = X_SIZE_DEF,
  parameter int Y_SIZE  = Y_SIZE_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int N_ENG   = 4,
  parameter int EW      = $clog2(N_ENG)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [EW-1:0]      eng_o,
  output logic               last_o
);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(Y_SIZE - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [EW-1:0]      eng_q, eng_d;

  // Next position: clear wins over increment; engine index wraps on its own width
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    eng_d = eng_q;
    if (clr_i) begin
      x_d   = '0;
      y_d   = '0;
      eng_d = '0;
    end else if (inc_i) begin
      eng_d = eng_q + EW'(1);
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      eng_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      eng_q <= eng_d;
    end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign eng_o  = eng_q;
  assign last_o = (x_q == XMAX) && (y_q == YMAX);
endmodule

// File: rtl/mandel_work_scheduler.sv
// Frame sequencer: round-robin pixel dispatch to N_ENG engines, per-engine
// result slots, and in-order re-emission of pixels towards the packer.
module mandel_work_scheduler
  import mandel_pkg::*;
#(
  parameter int N_ENG   = 4,
  parameter int X_SIZE  = X_SIZE_DEF,
  parameter int Y_SIZE  = Y_SIZE_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int RGB_W   = RGB_W_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_start,
  input  logic                   cfg_continuous,
  input  logic [31:0]            cfg_zoom_f,
  input  logic [31:0]            cfg_re_lower,
  input  logic [31:0]            cfg_im_upper,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic [31:0]            eng_zoom_f,
  output logic [31:0]            eng_re_lower,
  output logic [31:0]            eng_im_upper,
  output logic [COORD_W-1:0]     eng_x,
  output logic [COORD_W-1:0]     eng_y,
  output logic [N_ENG-1:0]       eng_start,
  input  logic [N_ENG-1:0]       eng_busy,
  input  logic [N_ENG-1:0]       eng_done,
  input  logic [N_ENG*RGB_W-1:0] eng_rgb,
  output logic [RGB_W-1:0]       out_rgb,
  output logic [COORD_W-1:0]     out_x,
  output logic [COORD_W-1:0]     out_y,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int EW = $clog2(N_ENG);

  state_t state_q, state_d;
  logic [31:0] zoom_q, rel_q, imu_q;
  logic [N_ENG-1:0][RGB_W-1:0] slot_q, rgb_in;
  logic [N_ENG-1:0] full_q, cap_ok;
  logic err_q, fd_q;
  logic [RGB_W-1:0]   orgb_q;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic osof_q, oeol_q, ovld_q, olast_q;

  logic frame_start, disp, byp, load, acc_last;
  logic [COORD_W-1:0] dx, dy, ex, ey;
  logic [EW-1:0] d_eng, e_eng;
  logic d_last, e_last;

  assign rgb_in = eng_rgb;

  // A result is only legal outside IDLE and into an empty slot
  assign cap_ok   = eng_done & ~full_q & {N_ENG{state_q != IDLE}};
  assign disp     = (state_q == RUN) && !eng_busy[d_eng] && !full_q[d_eng];
  // Bypass: the pixel due next can go straight to the output, skipping its slot
  assign byp      = cap_ok[e_eng];
  assign load     = (full_q[e_eng] || byp) && (!ovld_q || out_ready);
  assign acc_last = ovld_q && out_ready && olast_q;

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .COORD_W(COORD_W), .N_ENG(N_ENG)) u_disp (
    .clk_i(aclk), .rst_i(aresetn), .clr_i(frame_start), .inc_i(disp),
    .x_o(dx), .y_o(dy), .eng_o(d_eng), .last_o(d_last)
  );

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .COORD_W(COORD_W), .N_ENG(N_ENG)) u_emit (
    .clk_i(aclk), .rst_i(aresetn), .clr_i(frame_start), .inc_i(load),
    .x_o(ex), .y_o(ey), .eng_o(e_eng), .last_o(e_last)
  );

  // Frame FSM next state; frame_start marks the parameter latch / counter clear
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    unique case (state_q)
      IDLE:  if (cfg_start) begin
               frame_start = 1'b1;
               state_d     = RUN;
             end
      RUN:   if (disp && d_last) state_d = DRAIN;
      DRAIN: if (acc_last) begin
               if (cfg_continuous) begin
                 frame_start = 1'b1;
                 state_d     = RUN;
               end else begin
                 state_d = IDLE;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  // State, frame parameters, sticky error and frame_done pulse
  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) begin
      state_q <= IDLE;
      zoom_q  <= '0;
      rel_q   <= '0;
      imu_q   <= '0;
      err_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | (|(eng_done & ~cap_ok));
      fd_q    <= (state_q == DRAIN) && acc_last;
      if (frame_start) begin
        zoom_q <= cfg_zoom_f;
        rel_q  <= cfg_re_lower;
        imu_q  <= cfg_im_upper;
      end
    end

  // Result slots: fill on a legal eng_done unless bypassed, empty on emit
  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) begin
      slot_q <= '0;
      full_q <= '0;
    end else begin
      for (int i = 0; i < N_ENG; i++) begin
        if (cap_ok[i] && !(load && e_eng == EW'(i))) begin
          slot_q[i] <= rgb_in[i];
          full_q[i] <= 1'b1;
        end else if (load && e_eng == EW'(i)) begin
          full_q[i] <= 1'b0;
        end
      end
    end

  // Output register: holds while stalled, drops valid once taken with nothing new
  always_ff @(posedge aclk or posedge aresetn)
    if (aresetn) begin
      orgb_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      osof_q  <= 1'b0;
      oeol_q  <= 1'b0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
    end else if (load) begin
      orgb_q  <= full_q[e_eng] ? slot_q[e_eng] : rgb_in[e_eng];
      ox_q    <= ex;
      oy_q    <= ey;
      osof_q  <= (ex == '0) && (ey == '0);
      oeol_q  <= (ex == COORD_W'(X_SIZE - 1));
      ovld_q  <= 1'b1;
      olast_q <= e_last;
    end else if (out_ready) begin
      ovld_q <= 1'b0;
    end

  assign busy         = (state_q != IDLE);
  assign frame_done   = fd_q;
  assign err          = err_q;
  assign eng_zoom_f   = zoom_q;
  assign eng_re_lower = rel_q;
  assign eng_im_upper = imu_q;
  assign eng_x        = dx;
  assign eng_y        = dy;
  assign eng_start    = disp ? (N_ENG'(1) << d_eng) : '0;
  assign out_rgb      = orgb_q;
  assign out_x        = ox_q;
  assign out_y        = oy_q;
  assign out_sof      = osof_q;
  assign out_eol      = oeol_q;
  assign out_valid    = ovld_q;
endmodule

// File: tb/tb_mandel_work_scheduler.sv
// Bench: engine models with per-engine latency, randomized back-pressure,
// and a raster-order scoreboard derived from pixel index arithmetic.
module tb_mandel_work_scheduler;
  localparam int N = 4, XS = 8, YS = 2, CW = 10, RW = 24, NPIX = XS * YS;

  logic aclk = 1'b0, aresetn = 1'b1;
  logic cfg_start = 1'b0, cfg_continuous = 1'b0;
  logic [31:0] cfg_zoom_f = '0, cfg_re_lower = '0, cfg_im_upper = '0;
  logic busy, frame_done, err;
  logic [31:0] eng_zoom_f, eng_re_lower, eng_im_upper;
  logic [CW-1:0] eng_x, eng_y, out_x, out_y;
  logic [N-1:0] eng_start, eng_busy = '0, eng_done = '0;
  logic [N*RW-1:0] eng_rgb = '0;
  logic [RW-1:0] out_rgb;
  logic out_sof, out_eol, out_valid, out_ready = 1'b1;

  always #5 aclk = ~aclk;

  mandel_work_scheduler #(.N_ENG(N), .X_SIZE(XS), .Y_SIZE(YS), .COORD_W(CW), .RGB_W(RW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_continuous(cfg_continuous),
    .cfg_zoom_f(cfg_zoom_f), .cfg_re_lower(cfg_re_lower), .cfg_im_upper(cfg_im_upper),
    .busy(busy), .frame_done(frame_done), .err(err),
    .eng_zoom_f(eng_zoom_f), .eng_re_lower(eng_re_lower), .eng_im_upper(eng_im_upper),
    .eng_x(eng_x), .eng_y(eng_y), .eng_start(eng_start), .eng_busy(eng_busy),
    .eng_done(eng_done), .eng_rgb(eng_rgb),
    .out_rgb(out_rgb), .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // model state
  int lat[N], cnt[N], pix[N];
  int disp_cnt = 0, acc_cnt = 0, fd_cnt = 0, rdy_mode = 0;
  logic [19:0] salt = '0;
  // values captured just before a rising edge
  logic [N-1:0] c_st = '0;
  logic [CW-1:0] c_x = '0, c_y = '0, c_ox = '0, c_oy = '0;
  logic [RW-1:0] c_rgb = '0;
  logic c_acc = 0, c_sof = 0, c_eol = 0, c_cont = 0, c_stall = 0, c_stb = 0, exp_fd;
  int p, e, q;

  initial for (int i = 0; i < N; i++) begin lat[i] = 3; cnt[i] = 0; pix[i] = 0; end

  // Engines, back-pressure and scoreboard, all driven from the falling edge
  initial forever begin
    @(negedge aclk);
    exp_fd = 1'b0;
    if (c_acc) begin
      p = acc_cnt % NPIX;
      chk("out_x", c_ox, p % XS);
      chk("out_y", c_oy, p / XS);
      chk("out_rgb", c_rgb, {4'(p % N), salt ^ 20'(p)});
      chk("out_sof", c_sof, p == 0);
      chk("out_eol", c_eol, (p % XS) == XS - 1);
      exp_fd = (p == NPIX - 1);
      acc_cnt++;
    end
    chk("frame_done", frame_done, exp_fd);
    if (frame_done) begin
      fd_cnt++;
      chk("fd_busy", busy, c_cont);
    end
    if (c_stall)
      chk("stall_hold", {out_valid, out_rgb, out_x, out_y, out_sof, out_eol},
          {1'b1, c_rgb, c_ox, c_oy, c_sof, c_eol});
    eng_done = '0;
    for (int i = 0; i < N; i++)
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          eng_done[i] = 1'b1;
          eng_rgb[i*RW +: RW] = {4'(i), salt ^ 20'(pix[i])};
        end
      end
    if (c_st != '0) begin
      e = disp_cnt % N;
      q = disp_cnt % NPIX;
      chk("st_onehot", $onehot(c_st), 1);
      chk("st_eng", c_st, N'(1) << e);
      chk("eng_x", c_x, q % XS);
      chk("eng_y", c_y, q / XS);
      chk("st_to_busy", c_stb, 0);
      for (int i = 0; i < N; i++)
        if (c_st[i]) begin
          cnt[i] = lat[i];
          pix[i] = int'(c_y) * XS + int'(c_x);
        end
      disp_cnt++;
      chk("outstanding", (disp_cnt - acc_cnt) <= 2 * N + 1, 1);
    end
    for (int i = 0; i < N; i++) eng_busy[i] = (cnt[i] != 0) || eng_done[i];
    case (rdy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    #1;
    c_st    = eng_start;
    c_stb   = |(eng_start & eng_busy);
    c_x     = eng_x;
    c_y     = eng_y;
    c_acc   = out_valid && out_ready;
    c_stall = out_valid && !out_ready;
    c_rgb   = out_rgb;
    c_ox    = out_x;
    c_oy    = out_y;
    c_sof   = out_sof;
    c_eol   = out_eol;
    c_cont  = cfg_continuous;
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ctl"}, {busy, frame_done, err, out_valid, out_sof, out_eol, eng_start}, 0);
    chk({tag, "_pix"}, {out_rgb, out_x, out_y}, 0);
    chk({tag, "_disp"}, {eng_x, eng_y}, 0);
    chk({tag, "_par"}, {eng_zoom_f, eng_re_lower}, 0);
    chk({tag, "_im"}, eng_im_upper, 0);
  endtask

  task automatic start_frame(input logic [31:0] rel);
    cfg_zoom_f   = $urandom;
    cfg_re_lower = rel;
    cfg_im_upper = $urandom;
    cfg_start    = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("lat_zoom", eng_zoom_f, cfg_zoom_f);
    chk("lat_re", eng_re_lower, rel);
    chk("lat_im", eng_im_upper, cfg_im_upper);
  endtask

  task automatic wait_fd(input int n);
    for (int k = 0; k < 600 && fd_cnt < n; k++) tick();
    chk("fd_wait", fd_cnt, n);
  endtask

  int f0, a0;

  initial begin
    #1;
    zero_chk("rst");
    repeat (3) tick();
    aresetn = 1'b0;
    tick();
    zero_chk("post_rst");

    // single frame, uniform latency, always ready
    salt = 20'($urandom);
    f0 = fd_cnt; a0 = acc_cnt;
    start_frame($urandom);
    wait_fd(f0 + 1);
    repeat (5) tick();
    chk("fd_once", fd_cnt, f0 + 1);
    chk("busy_fall", busy, 0);
    chk("pix_count", acc_cnt - a0, NPIX);
    chk("err_f1", err, 0);

    // out-of-order engines, random back-pressure
    lat[0] = 9; lat[1] = 2; lat[2] = 5; lat[3] = 1;
    salt = 20'($urandom);
    rdy_mode = 1;
    f0 = fd_cnt; a0 = acc_cnt;
    start_frame($urandom);
    wait_fd(f0 + 1);
    rdy_mode = 0;
    repeat (3) tick();
    chk("pix_count_ooo", acc_cnt - a0, NPIX);
    chk("err_ooo", err, 0);

    // long stall mid-frame plus a config write that must not tear the frame
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 6);
    salt = 20'($urandom);
    f0 = fd_cnt; a0 = acc_cnt;
    start_frame(32'hFFC0_0000);
    for (int k = 0; k < 200 && acc_cnt < a0 + 5; k++) tick();
    chk("acc_wait", acc_cnt >= a0 + 5, 1);
    rdy_mode = 2;
    cfg_re_lower = 32'h0;
    repeat (20) tick();
    chk("re_hold_stall", eng_re_lower, 32'hFFC0_0000);
    rdy_mode = 0;
    wait_fd(f0 + 1);
    chk("re_hold_end", eng_re_lower, 32'hFFC0_0000);
    chk("pix_count_stall", acc_cnt - a0, NPIX);
    chk("err_stall", err, 0);

    // continuous mode: two back-to-back frames, new re_lower picked up
    cfg_continuous = 1'b1;
    f0 = fd_cnt; a0 = acc_cnt;
    start_frame(32'h0);
    wait_fd(f0 + 1);
    cfg_continuous = 1'b0;
    wait_fd(f0 + 2);
    repeat (3) tick();
    chk("pix_count_cont", acc_cnt - a0, 2 * NPIX);
    chk("busy_cont_end", busy, 0);
    chk("err_cont", err, 0);

    // reset mid-frame while engine 1 is still computing pixel 5
    for (int i = 0; i < N; i++) lat[i] = 6;
    a0 = disp_cnt;
    start_frame($urandom);
    for (int k = 0; k < 200 && disp_cnt < a0 + 6; k++) tick();
    chk("disp_wait", disp_cnt >= a0 + 6, 1);
    aresetn = 1'b1;
    #1;
    zero_chk("mid_rst");
    tick();
    aresetn = 1'b0;
    for (int k = 0; k < 20 && !err; k++) tick();
    chk("err_late_done", err, 1);
    chk("idle_after_rst", {busy, out_valid, eng_start}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vecs);
    $fatal(1);
  end
endmodule

// File: doc/mandel_work_scheduler.md
Name: mandel_work_scheduler

Overview:
- Sequences one Mandelbrot frame across N_ENG parallel iteration engines.
- Hands out pixel coordinates in raster order, one engine per pixel, round-robin.
- Collects engine results into a per-engine slot and re-emits them strictly in raster order, with sof/eol tags, towards the pixel packer.
- Latches frame parameters at frame start so that mid-frame register writes cannot tear a frame.

Parameters:
- N_ENG, 4, number of iteration engines (power of 2, 2..16)
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- COORD_W, 10, coordinate width
- RGB_W, 24, colour width

Ports:
- aclk  in  1  stream clock
- aresetn  in  1  asynchronous reset, active-high (driven from ~periph_resetn, as on the engine top level)
- cfg_start  in  1  single-cycle pulse; begin a frame
- cfg_continuous  in  1  when high, restart automatically after each frame
- cfg_zoom_f  in  32  Q-format step, sampled at frame start
- cfg_re_lower  in  32  sampled at frame start
- cfg_im_upper  in  32  sampled at frame start
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- err  out  1  sticky protocol error; cleared by reset only
- eng_zoom_f, eng_re_lower, eng_im_upper  out  32 each  latched frame parameters, broadcast to all engines
- eng_x  out  COORD_W  dispatched x, valid with eng_start
- eng_y  out  COORD_W  dispatched y, valid with eng_start
- eng_start  out  N_ENG  one-hot single-cycle dispatch strobe
- eng_busy  in  N_ENG  engine i is computing
- eng_done  in  N_ENG  one-cycle result strobe per engine
- eng_rgb  in  N_ENG*RGB_W  result of engine i, at bits [i*RGB_W +: RGB_W], valid with eng_done[i]
- out_rgb  out  RGB_W  pixel colour
- out_x  out  COORD_W  pixel x
- out_y  out  COORD_W  pixel y
- out_sof  out  1  high when out_x==0 and out_y==0
- out_eol  out  1  high when out_x==X_SIZE-1
- out_valid  out  1  output holds a pixel
- out_ready  in  1  packer can accept

Behaviour:
- Reset (async): state IDLE. All of the following are 0: outputs, slots, counters, latched parameters and err.
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE, on cfg_start:
  - latch the cfg_* values into eng_* registers;
  - clear the dispatch counters (dx, dy, d_eng) and emit counters (ex, ey, e_eng);
  - go to RUN; busy=1 from the next cycle.
- cfg_start outside IDLE is ignored.
- RUN, dispatch rule (at most one per cycle):
  - eng_start[d_eng]=1 iff !eng_busy[d_eng] and !slot_full[d_eng];
  - eng_x=dx and eng_y=dy in the same cycle;
  - then advance dx (wrap at X_SIZE-1, incrementing dy) and d_eng (mod N_ENG);
  - dispatching pixel (X_SIZE-1, Y_SIZE-1) moves the FSM to DRAIN.
- A busy or full engine stalls dispatch. Engines are never skipped, which guarantees that pixel p always maps to engine p mod N_ENG.
- Result capture (any state):
  - eng_done[i] writes eng_rgb slice i into slot i and sets slot_full[i];
  - multiple eng_done bits may be high in one cycle, and all are captured.
- Error cases (both leave the slot unchanged and set err):
  - eng_done[i] while slot_full[i] is already set;
  - eng_done[i] while in IDLE.
- Emit rule:
  - when (!out_valid || out_ready) and slot_full[e_eng]: load out_* from slot e_eng with ex/ey, set out_valid, clear slot_full[e_eng], advance ex/ey/e_eng;
  - if neither condition loads a new pixel and out_ready=1, clear out_valid.
  - Output is registered: latency from eng_done to out_valid is 1 cycle when the output is free.
  - out_* is stable while out_valid && !out_ready.
- Same cycle, same slot: a slot clear by emit and a dispatch to that same engine cannot coincide, because dispatch samples the registered slot_full.
- DRAIN: emitting pixel (X_SIZE-1, Y_SIZE-1) with out_ready high gives:
  - frame_done pulse in the next cycle;
  - then IDLE (busy=0), or an immediate new-frame latch and RUN if cfg_continuous=1.
- Arithmetic: counters are COORD_W bits, compared against X_SIZE-1 and Y_SIZE-1. Engine indices are $clog2(N_ENG) bits and wrap naturally.
- Reset mid-frame: everything is discarded. Engine results arriving later in IDLE set err, which lets the bench detect an unflushed engine.

Decomposition:
- Shared package mandel_pkg holds the COORD_W and RGB_W defaults, the X_SIZE/Y_SIZE constants, and the FSM state encodings (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10).
- One natural sub-module, raster_counter: holds x, y and the engine index, with inc, clear and last outputs. It is instantiated twice, once for dispatch and once for emit.

Test Plan (sim overrides: X_SIZE=8, Y_SIZE=2, N_ENG=4):
- Single frame, engines finish in 3 cycles, out_ready=1 → exactly 16 pixels emitted, out_x/out_y in raster order 0..7 per line, out_sof only on (0,0), out_eol on x=7, frame_done pulses once, busy falls.
- Engines given latencies 9/2/5/1 cycles (out of order) → output order is still raster, each out_rgb equals the tag engine i returned for pixel p with p mod 4 = i, err=0.
- out_ready held low for 20 cycles mid-frame → out_* stable while stalled, no dispatch to engines whose slot is full, no pixel lost or duplicated.
- cfg_re_lower changed from 0xFFC00000 to 0x00000000 mid-frame → eng_re_lower stays 0xFFC00000 until the next frame start.
- cfg_continuous=1 → the second frame starts with no IDLE gap, and frame_done pulses twice across 32 pixels.
- Reset asserted at pixel 5, and engine 1 returns eng_done after reset → all outputs 0, state IDLE, err=1.
